// File: rtl/stream_packet_arbiter.sv
// Round-robin, packet-locked stream arbiter: one owner drives the shared channel until its last beat.
// Optional grant statistics are built when STREAM_ARB_STATS_EN is defined.
module stream_packet_arbiter #(
    parameter int unsigned INPUT_NUM  = 3,
    parameter int unsigned DATA_WIDTH = 32
`ifdef STREAM_ARB_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] data_i [INPUT_NUM],
    input  logic [INPUT_NUM-1:0]  valid_i,
    input  logic [INPUT_NUM-1:0]  last_i,
    output logic [INPUT_NUM-1:0]  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i,
    output logic [INPUT_NUM-1:0]  grant_o,
    output logic                  busy_o
`ifdef STREAM_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant_cnt_o [INPUT_NUM]
`endif
);

    localparam int unsigned IDX_W = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {S_IDLE, S_LOCKED} state_e;

    state_e               state_q,   state_d;
    idx_t                 gnt_idx_q, gnt_idx_d;
    idx_t                 ptr_q,     ptr_d;
    logic [INPUT_NUM-1:0] grant_q,   grant_d;
    logic                 busy_q,    busy_d;

    idx_t                 sel_idx;
    logic                 sel_found;
    logic                 start;
    logic                 beat_done;
    int unsigned          cand;

    // First requesting index at or after the pointer, wrapping modulo INPUT_NUM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        sel_idx   = ptr_q;
        sel_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < INPUT_NUM; k++) begin
            cand = (32'(ptr_q) + k) % INPUT_NUM;
            if (!sel_found && valid_i[idx_t'(cand)]) begin
                sel_idx   = idx_t'(cand);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        ready_o = '0;
        data_o  = '0;
        valid_o = 1'b0;
        last_o  = 1'b0;
        if (state_q == S_LOCKED) begin
            valid_o            = valid_i[gnt_idx_q];
            last_o             = last_i[gnt_idx_q];
            data_o             = data_i[gnt_idx_q];
            ready_o[gnt_idx_q] = ready_i;
        end
    end

    assign start     = (state_q == S_IDLE) && sel_found;
    assign beat_done = (state_q == S_LOCKED) && valid_o && ready_i && last_o;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d          = S_LOCKED;
                    gnt_idx_d        = sel_idx;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            S_LOCKED: begin
                // Ownership ends only on the accepted last beat; stalls and valid gaps keep the lock.
                if (beat_done) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (gnt_idx_q == idx_t'(INPUT_NUM - 1)) ? '0 : gnt_idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: flops use non-blocking assignments so every register samples the same old values.
        if (ARESET) begin
            state_q   <= S_IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

`ifdef STREAM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [INPUT_NUM];
    logic [CNT_WIDTH-1:0] cnt_d [INPUT_NUM];

    // Saturating per-requester count of IDLE->LOCKED transitions.
    always_comb begin
        cnt_d = cnt_q;
        if (start && (cnt_q[sel_idx] != '1)) begin
            cnt_d[sel_idx] = cnt_q[sel_idx] + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`else
    // Arbitration only: no statistics state in this build.
`endif

endmodule
